// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit multicycle MIPS core:
// opcodes, datapath mux codes and the control FSM state type.
package mips16_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_J     = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_DEST = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_IMM  = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multicycle MIPS core: sequences
// fetch/decode/execute/memory/writeback and drives every datapath mux and strobe.
module multicycle_control
    import mips16_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter bit HALT_ILLEG = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic [1:0]          orig_pc,
    output logic                pc_en,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                halted,
    output state_t              debug_state
);

    state_t state;
    logic   dst_rd;

    assign debug_state = state;

    // Memory handshake: mem_read/mem_write act as a held request; the access
    // completes in the cycle where mem_ready=1 and the FSM advances on that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            dst_rd <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OPCODE_W'(OP_RTYPE): state <= S_EXEC_R;
                        OPCODE_W'(OP_ADDI):  state <= S_EXEC_I;
                        OPCODE_W'(OP_LW),
                        OPCODE_W'(OP_SW):    state <= S_MEM_ADDR;
                        OPCODE_W'(OP_BEQ):   state <= S_BRANCH;
                        OPCODE_W'(OP_J):     state <= S_JUMP;
                        OPCODE_W'(OP_HALT):  state <= S_HALT;
                        default:             state <= HALT_ILLEG ? S_HALT : S_FETCH;
                    endcase
                end
                S_EXEC_R: begin
                    dst_rd <= 1'b1;
                    state  <= S_WB_ALU;
                end
                S_EXEC_I: begin
                    dst_rd <= 1'b0;
                    state  <= S_WB_ALU;
                end
                S_WB_ALU:   state <= S_FETCH;
                S_MEM_ADDR: state <= (opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                S_WB_MEM:   state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JUMP:     state <= S_FETCH;
                S_HALT:     state <= S_HALT;
                default:    state <= S_IDLE;
            endcase
        end
    end

    // Outputs are held low while reset is asserted so an aborted instruction
    // can never commit a write or PC update in the reset cycle.
    always_comb begin
        orig_pc    = PCSRC_ALU;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        halted     = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_ONE;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_en    = 1'b1;
                    end
                end
                S_DECODE: alu_src_b = SRCB_IMM;
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SEXT;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = dst_rd;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_SUB;
                    orig_pc   = PCSRC_DEST;
                    pc_en     = alu_zero;
                end
                S_JUMP: begin
                    orig_pc = PCSRC_JUMP;
                    pc_en   = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
